sha256_host_ctrl: RTL

Host-side initiator for the simplified SHA-256 hasher. It accepts message words on a valid/ready stream and writes them into the shared word memory at MSG_ADDR. It then pulses the hasher's start and owns no memory cycles while the hasher runs. When the hasher finishes, it reads the 8-word digest back from OUT_ADDR and emits it on an output stream. It also contains the memory-port mux between the host and the hasher.

---
 rtl/sha256_host_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sha256_host_ctrl.sv
// Host-side initiator for the SHA-256 hasher: loads message words into shared memory,
// kicks the hasher, then streams the 8-word digest back out. Owns the memory-port mux.
module sha256_host_ctrl #(
  parameter int          NUM_OF_WORDS = 20,
  parameter logic [15:0] MSG_ADDR     = 16'h0000,
  parameter logic [15:0] OUT_ADDR     = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic        sha_mem_we,
  input  logic [15:0] sha_mem_addr,
  input  logic [31:0] sha_mem_write_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    LOAD,
    KICK,
    WAIT_LOW,
    WAIT_DONE,
    RD_ADDR,
    RD_CAP,
    EMIT
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'(NUM_OF_WORDS - 1);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [2:0]  rcnt_q, rcnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;

  logic [15:0] wr_addr;
  logic [15:0] rd_addr;

  assign wr_addr = MSG_ADDR + {8'h00, wcnt_q};
  assign rd_addr = OUT_ADDR + {13'h0000, rcnt_q};

  assign sha_message_addr = MSG_ADDR;
  assign sha_output_addr  = OUT_ADDR;
  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;
  assign busy             = (state_q != LOAD) || (wcnt_q != 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      wcnt_q      <= 8'h00;
      rcnt_q      <= 3'd0;
      out_data_q  <= 32'h0000_0000;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // The hasher owns the memory port only while it is running (WAIT_LOW/WAIT_DONE).
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    rcnt_d         = rcnt_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;
    in_ready       = 1'b0;
    sha_start      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = wr_addr;
    mem_write_data = 32'h0000_0000;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we         = 1'b1;
          mem_write_data = in_data;
          if (wcnt_q == LAST_WORD) begin
            wcnt_d  = 8'h00;
            state_d = KICK;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      KICK: begin
        sha_start = 1'b1;
        state_d   = WAIT_LOW;
      end
      WAIT_LOW: begin
        mem_we         = sha_mem_we;
        mem_addr       = sha_mem_addr;
        mem_write_data = sha_mem_write_data;
        if (!sha_done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        mem_we         = sha_mem_we;
        mem_addr       = sha_mem_addr;
        mem_write_data = sha_mem_write_data;
        if (sha_done) state_d = RD_ADDR;
      end
      RD_ADDR: begin
        mem_addr = rd_addr;
        state_d  = RD_CAP;
      end
      RD_CAP: begin
        mem_addr    = rd_addr;
        out_data_d  = mem_read_data;
        out_valid_d = 1'b1;
        out_last_d  = (rcnt_q == 3'd7);
        state_d     = EMIT;
      end
      EMIT: begin
        mem_addr = rd_addr;
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rcnt_d      = rcnt_q + 3'd1;
          state_d     = (rcnt_q == 3'd7) ? LOAD : RD_ADDR;
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule
